// File: rtl/aud_frame_sched.sv
// Stereo frame scheduler: round-robin merges two producers into a frame FIFO and
// streams left/right halves to an I2S serializer on LRCK edges. Optional macro: AUD_UNDERRUN_CNT_EN.
`timescale 1ns/1ps
module aud_frame_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          aud_lrck,
    input  logic [31:0]   src0_frame,
    input  logic          src0_valid,
    output logic          src0_ready,
    input  logic [31:0]   src1_frame,
    input  logic          src1_valid,
    output logic          src1_ready,
    output logic [15:0]   smpl,
    output logic          frame_pop,
    output logic          underrun,
    output logic [AW:0]   fill
`ifdef AUD_UNDERRUN_CNT_EN
    ,
    output logic [7:0]    underrun_cnt
`endif
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   fill_q, fill_d;
    logic          lrck_q;
    logic          rr_q, rr_d;
    logic [31:0]   hold_q, hold_d;
    logic [15:0]   smpl_q, smpl_d;
    logic          pop_q, under_q;

    logic          left_edge, right_edge, empty, full;
    logic          gnt0, gnt1, push, pop;
    logic [31:0]   wdata;

    always_comb begin
        left_edge  = lrck_q & ~aud_lrck;
        right_edge = ~lrck_q & aud_lrck;
        empty      = (fill_q == '0);
        full       = (fill_q == FULL);
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rr_d       = rr_q;
        // rr_q == 0 favours src0; the pointer only moves on contention
        if (!rst && !full) begin
            if (src0_valid && src1_valid) begin
                gnt0 = ~rr_q;
                gnt1 = rr_q;
                rr_d = ~rr_q;
            end else begin
                gnt0 = src0_valid;
                gnt1 = src1_valid;
            end
        end
        push  = gnt0 | gnt1;
        wdata = gnt1 ? src1_frame : src0_frame;
        // Pop only looks at registered fill, so a same-cycle push cannot cover an empty FIFO
        pop   = left_edge & ~empty;

        wr_d   = push ? wr_q + AW'(1) : wr_q;
        rd_d   = pop  ? rd_q + AW'(1) : rd_q;
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase

        hold_d = hold_q;
        smpl_d = smpl_q;
        if (left_edge) begin
            hold_d = pop ? mem_q[rd_q] : 32'd0;
            smpl_d = hold_d[31:16];
        end else if (right_edge) begin
            smpl_d = hold_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            lrck_q  <= 1'b0;
            rr_q    <= 1'b0;
            hold_q  <= '0;
            smpl_q  <= '0;
            pop_q   <= 1'b0;
            under_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            lrck_q  <= aud_lrck;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            smpl_q  <= smpl_d;
            pop_q   <= pop;
            under_q <= left_edge & empty;
        end
    end

    // Storage is data only; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= wdata;
        end
    end

`ifdef AUD_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_q <= '0;
        end else if (under_q && ucnt_q != 8'hFF) begin
            ucnt_q <= ucnt_q + 8'd1;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

    assign src0_ready = gnt0;
    assign src1_ready = gnt1;
    assign smpl       = smpl_q;
    assign frame_pop  = pop_q;
    assign underrun   = under_q;
    assign fill       = fill_q;

endmodule

// File: tb/tb_aud_frame_sched.sv
// Directed table-driven bench for aud_frame_sched plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_aud_frame_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        aud_lrck;
    logic [31:0] src0_frame, src1_frame;
    logic        src0_valid, src1_valid;
    logic        src0_ready, src1_ready;
    logic [15:0] smpl;
    logic        frame_pop, underrun;
    logic [3:0]  fill;
`ifdef AUD_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int checks = 0;
    int passes = 0;

    aud_frame_sched #(.DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .aud_lrck   (aud_lrck),
        .src0_frame (src0_frame),
        .src0_valid (src0_valid),
        .src0_ready (src0_ready),
        .src1_frame (src1_frame),
        .src1_valid (src1_valid),
        .src1_ready (src1_ready),
        .smpl       (smpl),
        .frame_pop  (frame_pop),
        .underrun   (underrun),
        .fill       (fill)
`ifdef AUD_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lrck;
        logic        v0;
        logic [31:0] f0;
        logic        v1;
        logic [31:0] f1;
        logic        r0;
        logic        r1;
        logic [15:0] smpl;
        logic        pop;
        logic        und;
        logic [3:0]  fill;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic l, input logic v0, input logic [31:0] f0,
                       input logic v1, input logic [31:0] f1);
        aud_lrck   = l;
        src0_valid = v0;
        src0_frame = f0;
        src1_valid = v1;
        src1_frame = f1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [15:0] s, input logic p,
                           input logic u, input logic [3:0] f);
        chk({nm, ".smpl"}, 32'(smpl), 32'(s));
        chk({nm, ".frame_pop"}, 32'(frame_pop), 32'(p));
        chk({nm, ".underrun"}, 32'(underrun), 32'(u));
        chk({nm, ".fill"}, 32'(fill), 32'(f));
    endtask

    initial begin
        logic [31:0] q [$];
        logic [31:0] last;
        logic [31:0] ff;
        int a, b;
        logic er0, er1;

        vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 32'h1111AAAA, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd1};
        vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 4'd0};
        vecs[9]  = '{1'b1, 1'b1, 32'h22223333, 1'b1, 32'h44445555, 1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0, 4'd1};
        vecs[10] = '{1'b1, 1'b1, 32'h66667777, 1'b1, 32'h44445555, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 4'd2};
        vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8888999A, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 4'd3};
        vecs[12] = '{1'b0, 1'b1, 32'h66667777, 1'b0, 32'h0, 1'b1, 1'b0, 16'h2222, 1'b1, 1'b0, 4'd3};
        vecs[13] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 4'd3};
        vecs[14] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h4444, 1'b1, 1'b0, 4'd2};
        vecs[15] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4'd2};
        vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h8888, 1'b1, 1'b0, 4'd1};
        vecs[17] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h999A, 1'b0, 1'b0, 4'd1};
        vecs[18] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h6666, 1'b1, 1'b0, 4'd0};
        vecs[19] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h7777, 1'b0, 1'b0, 4'd0};
        vecs[20] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0};
        vecs[21] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0};

        // Reset state, including ready held low while rst is high
        do_reset();
        rst = 1'b1;
        drv(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'hFEEDFACE);
        #1;
        chk("rst.ready0", 32'(src0_ready), 32'd0);
        chk("rst.ready1", 32'(src1_ready), 32'd0);
        chk_out("rst", 16'h0, 1'b0, 1'b0, 4'd0);
        drv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drv(vecs[i].lrck, vecs[i].v0, vecs[i].f0, vecs[i].v1, vecs[i].f1);
            #1;
            chk($sformatf("vec%0d.ready0", i), 32'(src0_ready), 32'(vecs[i].r0));
            chk($sformatf("vec%0d.ready1", i), 32'(src1_ready), 32'(vecs[i].r1));
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].smpl, vecs[i].pop, vecs[i].und, vecs[i].fill);
        end

        // Both sources saturating: alternate grants until full
        do_reset();
        a = 0;
        b = 0;
        for (int c = 0; c < 10; c++) begin
            drv(1'b0, 1'b1, {16'hA000 + 16'(a), 16'h5000 + 16'(a)},
                1'b1, {16'hB000 + 16'(b), 16'h6000 + 16'(b)});
            #1;
            er0 = (c < 8) && (c % 2 == 0);
            er1 = (c < 8) && (c % 2 == 1);
            chk($sformatf("rr%0d.ready0", c), 32'(src0_ready), 32'(er0));
            chk($sformatf("rr%0d.ready1", c), 32'(src1_ready), 32'(er1));
            if (er0) begin q.push_back(src0_frame); a++; end
            if (er1) begin q.push_back(src1_frame); b++; end
            tick();
            chk($sformatf("rr%0d.fill", c), 32'(fill), (c < 8) ? 32'(c + 1) : 32'd8);
        end

        // Full FIFO: pop cycle still blocks src1, grant follows next cycle
        ff = 32'hC0DE0001;
        drv(1'b1, 1'b0, 32'd0, 1'b1, ff);
        #1;
        chk("full.ready1_pre", 32'(src1_ready), 32'd0);
        tick();
        chk("full.fill_pre", 32'(fill), 32'd8);
        drv(1'b0, 1'b0, 32'd0, 1'b1, ff);
        #1;
        chk("full.ready1_popcyc", 32'(src1_ready), 32'd0);
        tick();
        last = q.pop_front();
        chk_out("full.pop", last[31:16], 1'b1, 1'b0, 4'd7);
        chk("full.ready1_after", 32'(src1_ready), 32'd1);
        q.push_back(ff);
        tick();
        chk("full.fill_refill", 32'(fill), 32'd8);
        for (int k = 0; k < 8; k++) begin
            drv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
            chk($sformatf("drain%0d.right", k), 32'(smpl), 32'(last[15:0]));
            drv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
            last = q.pop_front();
            chk_out($sformatf("drain%0d.left", k), last[31:16], 1'b1, 1'b0, 4'(7 - k));
        end
        drv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk("drain.last_right", 32'(smpl), 32'(last[15:0]));

        // Push into empty FIFO on the left-edge cycle: underrun, frame kept
        do_reset();
        drv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        drv(1'b0, 1'b1, 32'h12345678, 1'b0, 32'd0);
        #1;
        chk("emptypush.ready0", 32'(src0_ready), 32'd1);
        tick();
        chk_out("emptypush.left", 16'h0, 1'b0, 1'b1, 4'd1);
        drv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk_out("emptypush.right", 16'h0, 1'b0, 1'b0, 4'd1);
        drv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk_out("emptypush.next_left", 16'h1234, 1'b1, 1'b0, 4'd0);
        drv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk("emptypush.next_right", 32'(smpl), 32'h5678);

        // Mid-operation reset with fill=5 and pointer favouring src1
        do_reset();
        drv(1'b0, 1'b1, 32'h13572468, 1'b1, 32'h99990000);
        #1;
        chk("midrst.first_ready0", 32'(src0_ready), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drv(1'b0, 1'b1, 32'h20000000 + 32'(k), 1'b0, 32'd0);
            tick();
        end
        drv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        drv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk_out("midrst.pop", 16'h1357, 1'b1, 1'b0, 4'd4);
        drv(1'b0, 1'b1, 32'h30000000, 1'b0, 32'd0);
        tick();
        chk("midrst.fill5", 32'(fill), 32'd5);
        rst = 1'b1;
        drv(1'b0, 1'b1, 32'h40000000, 1'b1, 32'h50000000);
        #1;
        chk("midrst.ready0_in_rst", 32'(src0_ready), 32'd0);
        chk("midrst.ready1_in_rst", 32'(src1_ready), 32'd0);
        tick();
        chk_out("midrst.after", 16'h0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        #1;
        chk("midrst.ptr_ready0", 32'(src0_ready), 32'd1);
        chk("midrst.ptr_ready1", 32'(src1_ready), 32'd0);
        tick();
        drv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk_out("midrst.hold_cleared", 16'h0, 1'b0, 1'b0, 4'd1);

`ifdef AUD_UNDERRUN_CNT_EN
        do_reset();
        chk("ucnt.reset", 32'(underrun_cnt), 32'd0);
        for (int k = 0; k < 300; k++) begin
            drv(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
            drv(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
            if (k == 9) chk("ucnt.ten", 32'(underrun_cnt), 32'd9);
        end
        tick();
        chk("ucnt.sat", 32'(underrun_cnt), 32'd255);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
